// File: rtl/stream_mux_rr_if.sv
// Stream bundle for stream_mux_rr: N producer channels in, one registered consumer stream out.
// Packet-lock sideband (in_last/out_last) exists only when STREAM_MUX_PKT_LOCK_EN is defined.
interface stream_mux_rr_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// N:1 round-robin valid/ready stream mux, 1-cycle latency, full throughput; stalls in_ready while the output is held.
// Define STREAM_MUX_PKT_LOCK_EN to keep the grant on one channel until its in_last beat.
module stream_mux_rr #(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic          clk,
  input logic          rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam int IW = SW + 1;

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic          any_vld;
  logic          space;
  logic          load;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          lock_q, lock_d;
  logic          out_last_q, out_last_d;
  logic          grant_last;
`endif

  // Scan from the highest offset down so the closest valid channel after ptr wins.
  always_comb begin : arb
    logic [IW-1:0] idx;
    idx     = '0;
    grant   = '0;
    any_vld = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = {1'b0, ptr_q} + IW'(k);
      if (idx >= IW'(N)) idx = idx - IW'(N);
      if (bus.in_valid[idx[SW-1:0]]) begin
        grant   = idx[SW-1:0];
        any_vld = 1'b1;
      end
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      grant   = ptr_q;
      any_vld = bus.in_valid[ptr_q];
    end
`endif
  end

  always_comb begin
    grant_data = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    grant_last = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == grant) begin
        grant_data = bus.in_data[i*W +: W];
`ifdef STREAM_MUX_PKT_LOCK_EN
        grant_last = bus.in_last[i];
`endif
      end
    end
  end

  assign space = !out_valid_q || bus.out_ready;
  assign load  = space && any_vld;

  always_comb begin
    bus.in_ready = '0;
    if (load) bus.in_ready[grant] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant;
      ptr_d       = grant;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_d      = !grant_last;
      out_last_d  = grant_last;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to N-1 so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SW'(N - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance checked against a queue-free rule model.
// Directed scenarios first, then randomized producers and consumer stalls.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  stream_mux_rr_if #(.W(8), .N(4)) bus4 ();
  stream_mux_rr_if #(.W(8), .N(3)) bus3 ();

  stream_mux_rr #(.W(8), .N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  stream_mux_rr #(.W(8), .N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Stimulus per instance: index 0 is the N=4 mux, index 1 the N=3 mux.
  logic [3:0] t_vld [2];
  logic [7:0] t_dat [2][4];
  logic       t_ordy [2];
  logic [3:0] o_rdy [2];
  logic       o_vld [2];
  logic [7:0] o_dat [2];
  logic [1:0] o_sel [2];

  assign bus4.in_valid  = t_vld[0];
  assign bus4.in_data   = {t_dat[0][3], t_dat[0][2], t_dat[0][1], t_dat[0][0]};
  assign bus4.out_ready = t_ordy[0];
  assign bus3.in_valid  = t_vld[1][2:0];
  assign bus3.in_data   = {t_dat[1][2], t_dat[1][1], t_dat[1][0]};
  assign bus3.out_ready = t_ordy[1];

  assign o_rdy[0] = bus4.in_ready;
  assign o_vld[0] = bus4.out_valid;
  assign o_dat[0] = bus4.out_data;
  assign o_sel[0] = bus4.out_sel;
  assign o_rdy[1] = {1'b0, bus3.in_ready};
  assign o_vld[1] = bus3.out_valid;
  assign o_dat[1] = bus3.out_data;
  assign o_sel[1] = bus3.out_sel;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [3:0] t_lst [2];
  logic       o_last [2];
  assign bus4.in_last = t_lst[0];
  assign bus3.in_last = t_lst[1][2:0];
  assign o_last[0] = bus4.out_last;
  assign o_last[1] = bus3.out_last;
`endif

  // Reference model state: what the output register should hold and who was served last.
  logic       m_vld [2];
  logic [7:0] m_dat [2];
  int         m_sel [2];
  int         m_ptr [2];
  logic       m_lock [2];
  logic       m_last [2];
  int         acc [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int model_grant(input int d);
    int n;
    n = nch(d);
    if (m_lock[d]) return t_vld[d][m_ptr[d]] ? m_ptr[d] : -1;
    for (int k = 1; k <= n; k++) begin
      if (t_vld[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d]  = 1'b0;
      m_dat[d]  = 8'h00;
      m_sel[d]  = 0;
      m_ptr[d]  = nch(d) - 1;
      m_lock[d] = 1'b0;
      m_last[d] = 1'b0;
      acc[d]    = -1;
    end
  endtask

  // Inputs are already applied (after a negedge); check, advance the model, cross one rising edge.
  task automatic step();
    int   g;
    logic space;
    #1;
    for (int d = 0; d < 2; d++) begin
      g     = model_grant(d);
      space = !m_vld[d] || t_ordy[d];
      chk($sformatf("d%0d_vld", d), 32'(o_vld[d]), 32'(m_vld[d]));
      chk($sformatf("d%0d_dat", d), 32'(o_dat[d]), 32'(m_dat[d]));
      chk($sformatf("d%0d_sel", d), 32'(o_sel[d]), 32'(m_sel[d]));
      chk($sformatf("d%0d_rdy", d), 32'(o_rdy[d]), (space && g >= 0) ? (32'd1 << g) : 32'd0);
`ifdef STREAM_MUX_PKT_LOCK_EN
      chk($sformatf("d%0d_last", d), 32'(o_last[d]), 32'(m_last[d]));
`endif
      acc[d] = -1;
      if (space && g >= 0) begin
        m_vld[d] = 1'b1;
        m_dat[d] = t_dat[d][g];
        m_sel[d] = g;
        m_ptr[d] = g;
        acc[d]   = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
        m_lock[d] = !t_lst[d][g];
        m_last[d] = t_lst[d][g];
`endif
      end else if (t_ordy[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) t_vld[d] = 4'h0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_vld", tag, d), 32'(o_vld[d]), 32'd0);
      chk($sformatf("%s_d%0d_dat", tag, d), 32'(o_dat[d]), 32'd0);
      chk($sformatf("%s_d%0d_sel", tag, d), 32'(o_sel[d]), 32'd0);
      chk($sformatf("%s_d%0d_rdy", tag, d), 32'(o_rdy[d]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Producers drop a beat once accepted and hold it otherwise; idle channels start new beats at random.
  task automatic producers(input int pct);
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < nch(d); ch++) begin
        if (acc[d] == ch) t_vld[d][ch] = 1'b0;
        if (!t_vld[d][ch] && $urandom_range(99) < pct) begin
          t_vld[d][ch] = 1'b1;
          t_dat[d][ch] = 8'($urandom);
`ifdef STREAM_MUX_PKT_LOCK_EN
          t_lst[d][ch] = ($urandom_range(2) == 0);
`endif
        end
      end
      t_ordy[d] = ($urandom_range(9) < 7);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      t_vld[d]  = 4'h0;
      t_ordy[d] = 1'b1;
      for (int ch = 0; ch < 4; ch++) t_dat[d][ch] = 8'h00;
`ifdef STREAM_MUX_PKT_LOCK_EN
      t_lst[d] = 4'hF;
`endif
    end
    model_reset();
    do_reset("rst");

    // Single active channel: back-to-back beats, one cycle behind the input.
    t_vld[0][2] = 1'b1;
    t_dat[0][2] = 8'h11;
    step();
    chk("t2_b1", 32'(o_dat[0]), 32'h11);
    chk("t2_sel", 32'(o_sel[0]), 32'd2);
    t_dat[0][2] = 8'h22;
    step();
    chk("t2_b2", 32'(o_dat[0]), 32'h22);
    t_dat[0][2] = 8'h33;
    step();
    chk("t2_b3", 32'(o_dat[0]), 32'h33);
    t_vld[0][2] = 1'b0;
    step();
    chk("t2_idle", 32'(o_vld[0]), 32'd0);

    // All four channels valid: strict rotation from channel 0.
    do_reset("rst3");
    t_vld[0] = 4'hF;
    for (int ch = 0; ch < 4; ch++) t_dat[0][ch] = 8'(8'hA0 + ch);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_sel", 32'(o_sel[0]), 32'(i % 4));
      if (acc[0] >= 0) t_dat[0][acc[0]] = 8'(8'hA0 + i);
    end

    // Consumer stall: the held beat must not move and nothing is accepted.
    t_ordy[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_sel", 32'(o_sel[0]), 32'd3);
      chk("t4_dat", 32'(o_dat[0]), 32'hA3);
      chk("t4_rdy", 32'(o_rdy[0]), 32'd0);
    end
    t_ordy[0] = 1'b1;
    step();
    chk("t4_next", 32'(o_sel[0]), 32'd0);
    chk("t4_vld", 32'(o_vld[0]), 32'd1);

    // Three channels, wrap from index 2 back to 0.
    do_reset("rst5");
    t_vld[1] = 4'b0101;
    t_dat[1][0] = 8'h50;
    t_dat[1][2] = 8'h52;
    step();
    chk("t5_a", 32'(o_sel[1]), 32'd0);
    step();
    chk("t5_b", 32'(o_sel[1]), 32'd2);
    step();
    chk("t5_c", 32'(o_sel[1]), 32'd0);

    // Asynchronous reset while a beat is held.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(o_vld[1]), 32'd0);
    chk("arst_sel", 32'(o_sel[1]), 32'd0);
    chk("arst_dat", 32'(o_dat[1]), 32'd0);
    model_reset();
    t_vld[1] = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: channel 1 keeps the grant for its 3-beat packet.
    do_reset("rst6");
    t_vld[0][1] = 1'b1; t_dat[0][1] = 8'hB1; t_lst[0][1] = 1'b0;
    step();
    chk("t6_b1", 32'(o_sel[0]), 32'd1);
    t_vld[0][0] = 1'b1; t_dat[0][0] = 8'h0F; t_lst[0][0] = 1'b1;
    t_dat[0][1] = 8'hB2;
    step();
    chk("t6_b2", 32'(o_sel[0]), 32'd1);
    t_dat[0][1] = 8'hB3; t_lst[0][1] = 1'b1;
    step();
    chk("t6_b3", 32'(o_sel[0]), 32'd1);
    chk("t6_last", 32'(o_last[0]), 32'd1);
    t_vld[0][1] = 1'b0;
    step();
    chk("t6_ch0", 32'(o_sel[0]), 32'd0);
    t_vld[0][0] = 1'b0;
    t_vld[0][1] = 1'b1; t_dat[0][1] = 8'hC1; t_lst[0][1] = 1'b0;
    step();
    chk("t6_lock", 32'(o_sel[0]), 32'd1);
    do_reset("rst6b");
    t_vld[0] = 4'b0011;
    step();
    chk("t6_unlock", 32'(o_sel[0]), 32'd0);
`endif

    // Randomized traffic on both instances.
    do_reset("rstr");
    for (int c = 0; c < 3000; c++) begin
      producers(45);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
